mult_share_arbiter: RTL
=======================

// Module: mult_share_arbiter
// PURPOSE
//  Time-shares one 32x32 combinational multiplier (low 32 product bits) among
//  N_REQ requesters, e.g. upsampling/CSC, IDCT and dequant datapaths.
//  Arbitration is round-robin with optional short burst lock. Operands and
//  result are registered, giving a 2-cycle pipe at 1 multiply/cycle.
//  Sits between requester FSMs and the single multiplier instance.
// PARAMETERS
//  N_REQ     3   number of requesters (2..8)
//  MAX_LOCK  4   max consecutive grants one locked requester may hold (1..15)
// PORTS
//  Clock         in   1         system clock, all logic on rising edge
//  Reset         in   1         synchronous, active-high
//  req_valid     in   N_REQ     requester i has operands pending
//  req_lock      in   N_REQ     requester i asks to keep grant for next op
//  req_op_a      in   32*N_REQ  operand A, slice [32*i+31:32*i]
//  req_op_b      in   32*N_REQ  operand B, same slicing
//  req_ready     out  N_REQ     one-hot (or 0) grant; transfer = valid&ready
//  mult_op_1     out  32        registered operand A to multiplier
//  mult_op_2     out  32        registered operand B to multiplier
//  mult_result   in   32        multiplier product, low 32 bits
//  rsp_valid     out  N_REQ     one-hot, result belongs to requester i
//  rsp_result    out  32        registered product
//  busy          out  1         any pipe stage holds a valid op
// BEHAVIOUR
//  Reset: rr_ptr=0, lock_owner none, lock_cnt=0, s1/s2 valid=0; mult_op_1/2=0,
//   rsp_valid=0, rsp_result=0, busy=0. In-flight ops are dropped, no rsp.
//  Grant (combinational from req_valid, rr_ptr, lock state):
//   - If lock active and owner's req_valid=1, owner is granted.
//   - Else first i with req_valid[i] searching rr_ptr, rr_ptr+1, ... (mod N_REQ).
//   - No valid request: req_ready=0.
//  On transfer by i: rr_ptr <= (i+1) mod N_REQ; always one grant per cycle.
//  Lock FSM, states UNLOCKED / LOCKED(owner, cnt):
//   - UNLOCKED -> LOCKED(i,1) on transfer by i with req_lock[i]=1.
//   - LOCKED: transfer by owner with req_lock=1 and cnt<MAX_LOCK -> cnt+1.
//   - LOCKED -> UNLOCKED on: owner transfer with req_lock=0; owner req_valid=0
//     (lock lost, rr resumes); cnt==MAX_LOCK (forced release, next arbitration
//     is plain round-robin from rr_ptr = owner+1).
//   - MAX_LOCK=1 makes lock a no-op.
//  Pipeline (no backpressure; requesters must accept rsp):
//   - Cycle T: transfer. T+1: s1 holds ops on mult_op_1/2 + owner id.
//   - T+2: rsp_valid[owner]=1, rsp_result = mult_result captured at T+1.
//   - Latency 2, throughput 1/cycle; mult_op_1/2 hold last value when s1 idle.
//  Arithmetic: product is A*B mod 2^32; valid for two's-complement signed
//   operands when only low 32 bits are used. No saturation or overflow flag.
//  busy = s1_valid | s2_valid.
//  Simultaneous: all N requests at once -> served in rr order, one per cycle,
//   no starvation beyond (N_REQ-1)*MAX_LOCK cycles wait.
// TESTING
//  T1 reset: drive Reset 1 for 2 cycles mid-stream -> all outputs 0 next cycle,
//   no rsp_valid for dropped ops.
//  T2 single: req 0 valid, A=7, B=-3 at T -> rsp_valid=3'b001,
//   rsp_result=32'hFFFFFFEB at T+2.
//  T3 round-robin: all 3 valid continuously, no lock -> grant order 0,1,2,0,1,2;
//   results return in same order, 1 per cycle.
//  T4 lock: req 1 lock=1 continuously, others valid -> 1 granted 4 times,
//   then 2, 0, then 1 again.
//  T5 lock drop: req 2 locked, valid falls after 2 grants -> lock released,
//   next grant to lowest valid from rr_ptr=0.
//  T6 wrap: A=32'h0001_0000, B=32'h0001_0000 -> rsp_result=0;
//   A=B=32'hFFFFFFFF -> 1.

Source files
------------

// File: rtl/mult_share_arbiter_if.sv
// Request/response bundle between requesters, the
// shared-multiplier arbiter and the multiplier itself.
interface mult_share_arbiter_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_lock;
  logic [32*N_REQ-1:0] req_op_a;
  logic [32*N_REQ-1:0] req_op_b;
  logic [N_REQ-1:0]    req_ready;
  logic [31:0]         mult_op_1;
  logic [31:0]         mult_op_2;
  logic [31:0]         mult_result;
  logic [N_REQ-1:0]    rsp_valid;
  logic [31:0]         rsp_result;
  logic                busy;

  modport master (
    output req_valid,
    output req_lock,
    output req_op_a,
    output req_op_b,
    output mult_result,
    input  req_ready,
    input  mult_op_1,
    input  mult_op_2,
    input  rsp_valid,
    input  rsp_result,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_lock,
    input  req_op_a,
    input  req_op_b,
    input  mult_result,
    output req_ready,
    output mult_op_1,
    output mult_op_2,
    output rsp_valid,
    output rsp_result,
    output busy
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter with burst lock time-sharing one
// 32x32 multiplier; 2-cycle registered operand/result pipe.
module mult_share_arbiter #(
  parameter int N_REQ    = 3,
  parameter int MAX_LOCK = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  mult_share_arbiter_if.slave   arb_io
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = 4;
  localparam logic [CW-1:0] LAST_C = CW'(MAX_LOCK - 1);
  localparam logic [IW-1:0] TOP_ID = IW'(N_REQ - 1);
  localparam bit LOCK_EN = (MAX_LOCK > 1);

  typedef enum logic {
    UNLOCKED,
    LOCKED
  } lock_e;

  lock_e          lock_st_q, lock_st_d;
  logic [IW-1:0]  lock_own_q, lock_own_d;
  logic [CW-1:0]  lock_cnt_q, lock_cnt_d;
  logic [IW-1:0]  rr_ptr_q, rr_ptr_d;

  logic             s1_vld_q;
  logic [IW-1:0]    s1_id_q;
  logic [31:0]      op1_q;
  logic [31:0]      op2_q;
  logic [N_REQ-1:0] rsp_vld_q;
  logic [31:0]      rsp_res_q;

  logic             gnt_vld;
  logic [IW-1:0]    gnt_id;
  logic [N_REQ-1:0] gnt_oh;
  logic             own_hold;
  logic             gnt_lock;
  logic [31:0]      gnt_a;
  logic [31:0]      gnt_b;
  logic [N_REQ-1:0] s1_oh;

  // Grant: locked owner first, else first valid from rr_ptr
  always_comb begin
    int j;
    gnt_vld  = 1'b0;
    gnt_id   = '0;
    gnt_oh   = '0;
    own_hold = 1'b0;
    j        = 0;
    if (lock_st_q == LOCKED &&
        arb_io.req_valid[lock_own_q]) begin
      own_hold = 1'b1;
      gnt_vld  = 1'b1;
      gnt_id   = lock_own_q;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        j = int'(rr_ptr_q) + k;
        if (j >= N_REQ) j = j - N_REQ;
        if (!gnt_vld && arb_io.req_valid[j]) begin
          gnt_vld = 1'b1;
          gnt_id  = IW'(j);
        end
      end
    end
    if (gnt_vld) gnt_oh[gnt_id] = 1'b1;
  end

  // Operand mux for the granted requester
  always_comb begin
    gnt_a    = arb_io.req_op_a[int'(gnt_id)*32 +: 32];
    gnt_b    = arb_io.req_op_b[int'(gnt_id)*32 +: 32];
    gnt_lock = gnt_vld & arb_io.req_lock[gnt_id];
  end

  // Round-robin pointer and lock FSM next state
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_st_d  = lock_st_q;
    lock_own_d = lock_own_q;
    lock_cnt_d = lock_cnt_q;
    if (gnt_vld) begin
      rr_ptr_d = (gnt_id == TOP_ID) ? '0
               : gnt_id + 1'b1;
    end
    unique case (lock_st_q)
      UNLOCKED: begin
        if (LOCK_EN && gnt_lock) begin
          lock_st_d  = LOCKED;
          lock_own_d = gnt_id;
          lock_cnt_d = CW'(1);
        end
      end
      LOCKED: begin
        if (!own_hold) begin
          lock_st_d  = UNLOCKED;
          lock_own_d = '0;
          lock_cnt_d = '0;
          if (gnt_lock) begin
            lock_st_d  = LOCKED;
            lock_own_d = gnt_id;
            lock_cnt_d = CW'(1);
          end
        end else if (!gnt_lock ||
                     lock_cnt_q >= LAST_C) begin
          lock_st_d  = UNLOCKED;
          lock_own_d = '0;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      default: begin
        lock_st_d  = UNLOCKED;
        lock_own_d = '0;
        lock_cnt_d = '0;
      end
    endcase
  end

  // Arbitration state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_st_q  <= UNLOCKED;
      lock_own_q <= '0;
      lock_cnt_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_st_q  <= lock_st_d;
      lock_own_q <= lock_own_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // One-hot owner of the op in stage 1
  always_comb begin
    s1_oh = '0;
    s1_oh[s1_id_q] = 1'b1;
  end

  // Operand stage and result stage; ops hold when idle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld_q  <= 1'b0;
      s1_id_q   <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      rsp_vld_q <= '0;
      rsp_res_q <= '0;
    end else begin
      s1_vld_q <= gnt_vld;
      if (gnt_vld) begin
        s1_id_q <= gnt_id;
        op1_q   <= gnt_a;
        op2_q   <= gnt_b;
      end
      rsp_vld_q <= s1_vld_q ? s1_oh : '0;
      if (s1_vld_q) rsp_res_q <= arb_io.mult_result;
    end
  end

  assign arb_io.req_ready  = gnt_oh;
  assign arb_io.mult_op_1  = op1_q;
  assign arb_io.mult_op_2  = op2_q;
  assign arb_io.rsp_valid  = rsp_vld_q;
  assign arb_io.rsp_result = rsp_res_q;
  assign arb_io.busy       = s1_vld_q | (|rsp_vld_q);

endmodule
